// File: rtl/inst_fetch_ctrl_pkg.sv
// ============================================================================
// Module   : inst_fetch_ctrl_pkg
// Brief    : Shared fetch-sequencer definitions: state encodings and byte geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_fetch_ctrl_pkg;

    localparam int BYTES_PER_INST = 4;
    localparam int BYTE_W         = 8;
    localparam int INST_W         = BYTES_PER_INST * BYTE_W;

    typedef enum logic [2:0] {
        ST_B0     = 3'd0,
        ST_B1     = 3'd1,
        ST_B2     = 3'd2,
        ST_B3     = 3'd3,
        ST_HOLD   = 3'd4,
        ST_HALTED = 3'd5
    } fetch_state_t;

    // The byte states are encoded so that their low bits equal the byte index.
    function automatic logic is_byte_state(input fetch_state_t s);
        return (s == ST_B0) || (s == ST_B1) || (s == ST_B2) || (s == ST_B3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_word_assembler.sv
// ============================================================================
// Module   : inst_word_assembler
// Brief    : Byte-lane merge register; lane k lands in word[31-8k -: 8] (big-endian).
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_word_assembler
    import inst_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [1:0]        i_lane,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [INST_W-1:0] o_word
);

    logic [INST_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (i_load) begin
            for (int l = 0; l < BYTES_PER_INST; l++) begin
                if (i_lane == 2'(l)) begin
                    r_word[(BYTES_PER_INST-1-l)*BYTE_W +: BYTE_W] <= i_byte;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : Byte-serial instruction fetch sequencer with redirect/halt and a
//            valid/ready word interface. Optional macro FETCH_ALIGN_CHECK_EN
//            enables the sticky misaligned-redirect fault.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BYTE_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              fault
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_fault;

    logic              w_busy;
    logic [1:0]        w_lane;
    logic              w_misaligned;
    logic              w_asm_load;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_busy     = is_byte_state(r_state);
    assign w_lane     = r_state[1:0];
    // A redirecting cycle discards the byte instead of merging it.
    assign w_asm_load = w_busy && !redirect_valid;

    always_comb begin
        rom_addr = r_fetch_pc;
        if (w_busy) begin
            rom_addr = r_fetch_pc + {{(ADDR_W-2){1'b0}}, w_lane};
        end
    end

    inst_word_assembler u_asm (
        .clk    (CLK),
        .rst_n  (Reset),
        .i_load (w_asm_load),
        .i_lane (w_lane),
        .i_byte (rom_data),
        .o_word (inst)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state      <= ST_B0;
            r_fetch_pc   <= RESET_PC;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else if (r_fault) begin
            r_state <= ST_HALTED;
        end else if (redirect_valid) begin
            // Also covers redirect+ready in HOLD: dropping valid consumes the word.
            r_inst_valid <= 1'b0;
            if (w_misaligned) begin
                r_fault <= 1'b1;
                r_state <= ST_HALTED;
            end else begin
                r_fetch_pc <= redirect_pc;
                r_state    <= ST_B0;
            end
        end else begin
            case (r_state)
                ST_B0: r_state <= ST_B1;
                ST_B1: r_state <= ST_B2;
                ST_B2: r_state <= ST_B3;
                ST_B3: begin
                    r_inst_pc    <= r_fetch_pc;
                    r_inst_valid <= 1'b1;
                    r_state      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_fetch_pc   <= r_fetch_pc + ADDR_W'(BYTES_PER_INST);
                        r_state      <= halt ? ST_HALTED : ST_B0;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        r_state <= ST_B0;
                    end
                end
                default: r_state <= ST_B0;
            endcase
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst_pc    = r_inst_pc;
    assign busy       = w_busy;
    assign fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Directed scenarios plus randomized traffic against a word-level
//            reference model of the fetch sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_ctrl;

    localparam int M_FETCH = 0;
    localparam int M_HOLD  = 1;
    localparam int M_STOP  = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] rom_addr;
    logic [7:0]  rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        busy;
    logic        fault;

    logic [7:0]  rom [256];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: a word is fetched over 4 cycles, then held until taken.
    int          m_mode;
    int          m_k;
    logic [31:0] m_pc;
    logic [31:0] m_inst_pc;
    logic [31:0] m_inst;
    bit          m_valid;
    bit          m_fault;

    always #5 CLK = ~CLK;

    assign rom_data = rom[rom_addr[7:0]];

    inst_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .busy           (busy),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = a + 32'(i);
            w = {w[23:0], rom[b[7:0]]};
        end
        return w;
    endfunction

    task automatic model_update();
        if (!Reset) begin
            m_mode = M_FETCH; m_k = 0; m_pc = 32'h0;
            m_inst = '0; m_inst_pc = '0; m_valid = 0; m_fault = 0;
        end else if (m_fault) begin
            m_mode = M_STOP;
        end else if (redirect_valid) begin
            m_valid = 0;
            if (ALIGN_EN && redirect_pc[1:0] != 2'b00) begin
                m_fault = 1; m_mode = M_STOP;
            end else begin
                m_pc = redirect_pc; m_mode = M_FETCH; m_k = 0;
            end
        end else if (m_mode == M_FETCH) begin
            if (m_k == 3) begin
                m_inst = word_at(m_pc); m_inst_pc = m_pc;
                m_valid = 1; m_mode = M_HOLD;
            end else begin
                m_k++;
            end
        end else if (m_mode == M_HOLD) begin
            if (inst_ready) begin
                m_valid = 0; m_pc = m_pc + 4; m_k = 0;
                m_mode = halt ? M_STOP : M_FETCH;
            end
        end else if (!halt) begin
            m_mode = M_FETCH; m_k = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        chk("rom_addr", rom_addr, (m_mode == M_FETCH) ? m_pc + 32'(m_k) : m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_mode == M_FETCH));
        chk("fault", 32'(fault), 32'(m_fault));
        if (m_valid) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
        tick();
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        Reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        int n;
        bit saw_pc0;
        logic [31:0] seq [8];
        seq = '{32'h20, 32'h08, 32'h00, 32'h05, 32'h8C, 32'h02, 32'h00, 32'h04};
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) rom[i] = seq[i][7:0];
        Reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b0;
        m_mode = M_FETCH; m_k = 0; m_pc = 0; m_inst = 0; m_inst_pc = 0; m_valid = 0; m_fault = 0;

        // 1: sequential fetch, latency and throughput
        inst_ready = 1'b1;
        do_reset();
        chk("t1_addr0", rom_addr, 32'h0);
        wait_valid("t1_v0", n);
        chk("t1_lat", 32'(n), 32'd4);
        chk("t1_inst0", inst, 32'h20080005);
        chk("t1_pc0", inst_pc, 32'h0);
        tick();
        wait_valid("t1_v1", n);
        chk("t1_thru", 32'(n + 1), 32'd5);
        chk("t1_inst1", inst, 32'h8C020004);
        chk("t1_pc1", inst_pc, 32'h4);

        // 2: backpressure
        inst_ready = 1'b0;
        do_reset();
        wait_valid("t2_v0", n);
        for (int i = 0; i < 10; i++) tick();
        chk("t2_inst", inst, 32'h20080005);
        chk("t2_addr", rom_addr, 32'h0);
        inst_ready = 1'b1;
        tick();
        wait_valid("t2_v1", n);
        chk("t2_pc1", inst_pc, 32'h4);

        // 3: redirect during B2 discards the partial word
        do_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect_valid = 1'b0;
        saw_pc0 = 0;
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t3_v", 32'(inst_valid), 32'd1);
        chk("t3_inst", inst, 32'h8C020004);
        chk("t3_pc", inst_pc, 32'h4);

        // 4: redirect with ready in HOLD consumes the word and overrides +4
        do_reset();
        wait_valid("t4_v0", n);
        tick();
        wait_valid("t4_v1", n);
        chk("t4_pc1", inst_pc, 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        wait_valid("t4_v2", n);
        chk("t4_pc2", inst_pc, 32'h0);
        chk("t4_inst2", inst, 32'h20080005);

        // 5: halt mid-word takes effect at the handshake
        do_reset();
        tick();
        halt = 1'b1;
        wait_valid("t5_v0", n);
        chk("t5_pc0", inst_pc, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_addr", rom_addr, 32'h4);
        halt = 1'b0;
        wait_valid("t5_v1", n);
        chk("t5_pc1", inst_pc, 32'h4);

        // 6: unaligned redirect
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_fault", 32'(fault), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_sticky", 32'(fault), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);
        do_reset();
        chk("t6_clr", 32'(fault), 32'd0);
        wait_valid("t6_v", n);
        chk("t6_pc", inst_pc, 32'h0);
`else
        redirect_valid = 1'b0;
        chk("t6_a6", rom_addr, 32'h6);
        tick(); chk("t6_a7", rom_addr, 32'h7);
        tick(); chk("t6_a8", rom_addr, 32'h8);
        tick(); chk("t6_a9", rom_addr, 32'h9);
        wait_valid("t6_v", n);
        chk("t6_pc", inst_pc, 32'h6);
        chk("t6_hi", {16'h0, inst[31:16]}, 32'h0004);
`endif

        // Wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_valid("wrap_v", n);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wrap_addr", rom_addr, 32'h1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            Reset          = ($urandom_range(99) != 0);
            redirect_valid = ($urandom_range(11) == 0);
            case ($urandom_range(7))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = 32'hFFFF_FFFE;
                2:       redirect_pc = 32'($urandom_range(63));
                default: redirect_pc = 32'($urandom_range(63)) & 32'hFFFF_FFFC;
            endcase
            halt       = ($urandom_range(5) == 0);
            inst_ready = ($urandom_range(2) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
